// File: rtl/uart_tx_bit_sequencer.sv
// rtl/uart_tx_bit_sequencer.sv - UART Tx bit-timing and frame sequencer
module uart_tx_bit_sequencer #(
    parameter  int DATA_WIDTH     = 8,
    parameter  int PRESCALE_WIDTH = 16,
    localparam int IDX_WIDTH      = $clog2(DATA_WIDTH)
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      Start,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    input  logic                      Par_En,
    input  logic                      Two_Stop,
    output logic                      Busy,
    output logic [1:0]                Bit_Sel,
    output logic [IDX_WIDTH-1:0]      Bit_Index,
    output logic                      Shift_En,
    output logic                      Done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(DATA_WIDTH - 1);

    state_t                    state_q, state_d;
    logic [PRESCALE_WIDTH-1:0] baud_q, baud_d;
    logic [PRESCALE_WIDTH-1:0] p_m1_q, p_m1_d;
    logic [IDX_WIDTH-1:0]      idx_q, idx_d;
    logic                      stop_q, stop_d;
    logic                      par_q, par_d;
    logic                      two_q, two_d;

    logic                      bit_end;
    logic                      accept;
    logic [PRESCALE_WIDTH-1:0] p_in_m1;

    // Flat decode from registered state: Done/Shift_En never see the inputs
    always_comb begin
        bit_end   = (baud_q == '0);
        Busy      = (state_q != S_IDLE);
        Shift_En  = (state_q == S_DATA) && bit_end;
        Done      = (state_q == S_STOP) && bit_end && !stop_q;
        Bit_Index = idx_q;
        Bit_Sel   = 2'b00;
        case (state_q)
            S_START:  Bit_Sel = 2'b01;
            S_DATA:   Bit_Sel = 2'b10;
            S_PARITY: Bit_Sel = 2'b11;
            default:  Bit_Sel = 2'b00;
        endcase
        // A new frame is taken when idle or in the final cycle of a frame
        accept  = Start && ((state_q == S_IDLE) || Done);
        // Prescale of 0 behaves as 1, so the reload value saturates at 0
        p_in_m1 = (Prescale == '0) ? '0 : Prescale - 1'b1;
    end

    // Next-state and counter logic for the frame walk
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        p_m1_d  = p_m1_q;
        idx_d   = idx_q;
        stop_d  = stop_q;
        par_d   = par_q;
        two_d   = two_q;

        if (accept) begin
            state_d = S_START;
            baud_d  = p_in_m1;
            p_m1_d  = p_in_m1;
            par_d   = Par_En;
            two_d   = Two_Stop;
            idx_d   = '0;
            stop_d  = 1'b0;
        end else begin
            case (state_q)
                S_START: begin
                    if (bit_end) begin
                        state_d = S_DATA;
                        baud_d  = p_m1_q;
                        idx_d   = '0;
                    end else begin
                        baud_d = baud_q - 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        baud_d = p_m1_q;
                        if (idx_q != LAST_IDX) begin
                            idx_d = idx_q + 1'b1;
                        end else if (par_q) begin
                            state_d = S_PARITY;
                        end else begin
                            state_d = S_STOP;
                            stop_d  = two_q;
                        end
                    end else begin
                        baud_d = baud_q - 1'b1;
                    end
                end
                S_PARITY: begin
                    if (bit_end) begin
                        state_d = S_STOP;
                        baud_d  = p_m1_q;
                        stop_d  = two_q;
                    end else begin
                        baud_d = baud_q - 1'b1;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        if (stop_q) begin
                            // First of two stop bits finished; run the second
                            stop_d = 1'b0;
                            baud_d = p_m1_q;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        baud_d = baud_q - 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and counter registers; async reset discards any frame in flight
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            p_m1_q  <= '0;
            idx_q   <= '0;
            stop_q  <= 1'b0;
            par_q   <= 1'b0;
            two_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            p_m1_q  <= p_m1_d;
            idx_q   <= idx_d;
            stop_q  <= stop_d;
            par_q   <= par_d;
            two_q   <= two_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_bit_sequencer.sv
// tb/tb_uart_tx_bit_sequencer.sv - scoreboard bench for uart_tx_bit_sequencer
module tb_uart_tx_bit_sequencer;

    localparam int DW = 8;
    localparam int PW = 16;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          Start = 1'b0;
    logic [PW-1:0] Prescale = '0;
    logic          Par_En = 1'b0;
    logic          Two_Stop = 1'b0;
    logic          Busy;
    logic [1:0]    Bit_Sel;
    logic [2:0]    Bit_Index;
    logic          Shift_En;
    logic          Done;

    // Observation word layout: {Busy, Bit_Sel[1:0], Bit_Index[2:0], Shift_En, Done}
    logic [7:0] sb[$];
    logic [7:0] cur_exp = 8'h00;
    logic [2:0] last_idx = 3'd0;
    int         n_checks = 0;
    int         n_fail = 0;

    uart_tx_bit_sequencer #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) u_dut (
        .CLK       (CLK),
        .RST       (RST),
        .Start     (Start),
        .Prescale  (Prescale),
        .Par_En    (Par_En),
        .Two_Stop  (Two_Stop),
        .Busy      (Busy),
        .Bit_Sel   (Bit_Sel),
        .Bit_Index (Bit_Index),
        .Shift_En  (Shift_En),
        .Done      (Done)
    );

    always #5 CLK = ~CLK;

    // Expected per-cycle outputs of one whole frame, derived from bit timing
    task automatic push_frame(input int p_in, input bit par, input bit two);
        int p, len, b;
        logic [1:0] sel;
        logic [2:0] idx;
        bit sh;
        p   = (p_in == 0) ? 1 : p_in;
        len = p * (2 + DW + int'(par) + int'(two));
        for (int c = 0; c < len; c++) begin
            b  = c / p;
            sh = 1'b0;
            if (b == 0) begin
                sel = 2'b01; idx = 3'd0;
            end else if (b <= DW) begin
                sel = 2'b10; idx = 3'(b - 1); sh = ((c % p) == p - 1);
            end else if (par && b == DW + 1) begin
                sel = 2'b11; idx = 3'(DW - 1);
            end else begin
                sel = 2'b00; idx = 3'(DW - 1);
            end
            sb.push_back({1'b1, sel, idx, sh, (c == len - 1)});
        end
    endtask

    // Advance one clock; push a frame if the model says Start is accepted
    task automatic tick(output logic [7:0] obs, output logic [7:0] exp);
        bit acc;
        acc = Start && (!cur_exp[7] || cur_exp[0]);
        @(posedge CLK);
        if (acc) push_frame(int'(Prescale), Par_En, Two_Stop);
        @(negedge CLK);
        obs = {Busy, Bit_Sel, Bit_Index, Shift_En, Done};
        if (sb.size() > 0) exp = sb.pop_front();
        else exp = {1'b0, 2'b00, last_idx, 1'b0, 1'b0};
        cur_exp  = exp;
        last_idx = exp[4:2];
    endtask

    task automatic test_reset();
        logic [7:0] obs, exp;
        obs = {Busy, Bit_Sel, Bit_Index, Shift_En, Done};
        n_checks++;
        if (obs !== 8'h00) begin
            n_fail++; $display("FAIL reset_hold: got %b expected %b", obs, 8'h00);
        end
        @(negedge CLK);
        RST = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick(obs, exp);
            n_checks++;
            if (obs !== 8'h00) begin
                n_fail++; $display("FAIL reset_idle c%0d: got %b expected %b", c, obs, 8'h00);
            end
        end
    endtask

    task automatic test_basic_p4();
        logic [7:0] obs, exp;
        int shifts = 0, done_at = -1;
        Prescale = 16'd4; Par_En = 1'b0; Two_Stop = 1'b0; Start = 1'b1;
        for (int c = 0; c < 41; c++) begin
            tick(obs, exp);
            Start = 1'b0;
            n_checks++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL basic c%0d: got %b expected %b", c, obs, exp);
            end
            if (obs[1]) shifts++;
            if (obs[0]) done_at = c;
        end
        n_checks++;
        if (shifts != 8) begin
            n_fail++; $display("FAIL basic_shift_count: got %0d expected 8", shifts);
        end
        n_checks++;
        if (done_at != 39) begin
            n_fail++; $display("FAIL basic_done_cycle: got %0d expected 39", done_at);
        end
    endtask

    task automatic test_parity_two_stop();
        logic [7:0] obs, exp;
        int par_cycles = 0, done_at = -1;
        Prescale = 16'd2; Par_En = 1'b1; Two_Stop = 1'b1; Start = 1'b1;
        for (int c = 0; c < 26; c++) begin
            tick(obs, exp);
            Start = 1'b0;
            n_checks++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL parity c%0d: got %b expected %b", c, obs, exp);
            end
            if (obs[6:5] == 2'b11 && (c == 18 || c == 19)) par_cycles++;
            if (obs[0]) done_at = c;
        end
        n_checks++;
        if (par_cycles != 2) begin
            n_fail++; $display("FAIL parity_cycles: got %0d expected 2", par_cycles);
        end
        n_checks++;
        if (done_at != 23) begin
            n_fail++; $display("FAIL parity_done_cycle: got %0d expected 23", done_at);
        end
        Par_En = 1'b0; Two_Stop = 1'b0;
    endtask

    task automatic test_prescale_zero();
        logic [7:0] obs, exp;
        int first_sh = -1, last_sh = -1, done_at = -1;
        Prescale = 16'd0; Start = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick(obs, exp);
            Start = 1'b0;
            n_checks++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL p0 c%0d: got %b expected %b", c, obs, exp);
            end
            if (obs[1] && first_sh < 0) first_sh = c;
            if (obs[1]) last_sh = c;
            if (obs[0]) done_at = c;
        end
        n_checks++;
        if (first_sh != 1 || last_sh != 8 || done_at != 9) begin
            n_fail++;
            $display("FAIL p0_timing: got shift %0d..%0d done %0d expected shift 1..8 done 9",
                     first_sh, last_sh, done_at);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] obs, exp;
        int drops = 0, dones = 0, bad_follow = 0;
        bit prev_done = 1'b0;
        Prescale = 16'd3; Start = 1'b1;
        for (int c = 0; c < 90; c++) begin
            tick(obs, exp);
            n_checks++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL b2b c%0d: got %b expected %b", c, obs, exp);
            end
            if (!obs[7]) drops++;
            if (obs[0]) begin
                dones++;
                if ((c % 30) != 29) bad_follow++;
            end
            if (prev_done && obs[6:5] != 2'b01) bad_follow++;
            prev_done = obs[0];
        end
        Start = 1'b0;
        for (int c = 90; c < 92; c++) begin
            tick(obs, exp);
            n_checks++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL b2b_tail c%0d: got %b expected %b", c, obs, exp);
            end
        end
        n_checks++;
        if (drops != 0 || dones != 3 || bad_follow != 0) begin
            n_fail++;
            $display("FAIL b2b_summary: got drops %0d dones %0d bad %0d expected 0 3 0",
                     drops, dones, bad_follow);
        end
    endtask

    task automatic test_mid_frame_ignore();
        logic [7:0] obs, exp;
        int busy_cycles = 0;
        Prescale = 16'd4; Start = 1'b1;
        for (int c = 0; c < 46; c++) begin
            tick(obs, exp);
            Start = (c >= 9 && c <= 11);
            if (c == 9) Prescale = 16'd9;
            n_checks++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL midframe c%0d: got %b expected %b", c, obs, exp);
            end
            if (obs[7]) busy_cycles++;
        end
        n_checks++;
        if (busy_cycles != 40) begin
            n_fail++; $display("FAIL midframe_length: got %0d expected 40", busy_cycles);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] obs, exp;
        Prescale = 16'd4; Start = 1'b1;
        for (int c = 0; c < 21; c++) begin
            tick(obs, exp);
            Start = 1'b0;
        end
        RST = 1'b0;
        #1;
        obs = {Busy, Bit_Sel, Bit_Index, Shift_En, Done};
        n_checks++;
        if (obs !== 8'h00) begin
            n_fail++; $display("FAIL rst_async: got %b expected %b", obs, 8'h00);
        end
        sb.delete();
        cur_exp  = 8'h00;
        last_idx = 3'd0;
        @(posedge CLK);
        @(negedge CLK);
        obs = {Busy, Bit_Sel, Bit_Index, Shift_En, Done};
        n_checks++;
        if (obs !== 8'h00) begin
            n_fail++; $display("FAIL rst_held: got %b expected %b", obs, 8'h00);
        end
        RST = 1'b1;
        Start = 1'b1;
        for (int c = 0; c < 41; c++) begin
            tick(obs, exp);
            Start = 1'b0;
            n_checks++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL rst_fresh c%0d: got %b expected %b", c, obs, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_p4();
        test_parity_two_stop();
        test_prescale_zero();
        test_back_to_back();
        test_mid_frame_ignore();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time budget");
        $fatal(1);
    end

endmodule
